// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the instruction-memory request, tracks the
// fetch PC and loads the IF/ID pipeline register. Supports load-use stalls,
// branch/jump redirects (flush) and memories with wait states.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCwrite,
  input  logic        IF_IDwrite,
  input  logic        flush,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] IF_IDpc,
  output logic [31:0] IF_IDinstr,
  output logic        IF_IDvalid
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,  // request outstanding at pc_q
    S_HOLD  = 2'd1,  // fetched word buffered, waiting for stall to clear
    S_DRAIN = 2'd2   // in-flight word from before a redirect is discarded
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] drain_addr_q, drain_addr_d;

  logic advance;
  assign advance = PCwrite & IF_IDwrite;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_REQ;
    else       state_q <= state_d;
  end

  // Next-state decode; flush wins over stall in every state.
  // NOTE: the default assignment at the top keeps every path assigned, so no
  // latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_REQ: begin
        if (flush)                      state_d = imem_ready ? S_REQ : S_DRAIN;
        else if (imem_ready && !advance) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (flush || advance) state_d = S_REQ;
      end
      S_DRAIN: begin
        // A flush here only retargets pc; the old request must still complete.
        if (imem_ready) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  // Memory interface decoded from registered state only, so the request
  // address cannot glitch on imem_ready, PCwrite or flush.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc_q;
    unique case (state_q)
      S_REQ:   imem_req = 1'b1;
      S_DRAIN: begin
        imem_req  = 1'b1;
        imem_addr = drain_addr_q;
      end
      default: imem_req = 1'b0;
    endcase
  end

  // Datapath next values: pc, IF/ID, hold buffer, drain address.
  always_comb begin
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    hold_d       = hold_q;
    drain_addr_d = drain_addr_q;
    if (flush) begin
      pc_d         = branch_target;
      ifid_pc_d    = branch_target;
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
      hold_d       = '0;
      // Only a still-pending request needs its address kept for draining.
      if (state_q == S_REQ && !imem_ready) drain_addr_d = pc_q;
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (imem_ready) begin
            if (advance) begin
              ifid_pc_d    = pc_q;
              ifid_instr_d = imem_rdata;
              ifid_valid_d = 1'b1;
              pc_d         = pc_q + 32'd4;
            end else begin
              hold_d = imem_rdata;
            end
          end else if (IF_IDwrite) begin
            ifid_pc_d    = pc_q;
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
          end
        end
        S_HOLD: begin
          if (advance) begin
            ifid_pc_d    = pc_q;
            ifid_instr_d = hold_q;
            ifid_valid_d = 1'b1;
            pc_d         = pc_q + 32'd4;
          end
        end
        S_DRAIN: begin
          // Returned data is dropped; downstream only ever sees bubbles.
          if (IF_IDwrite) begin
            ifid_pc_d    = pc_q;
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers with asynchronous reset to the architectural reset state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      ifid_pc_q    <= RESET_PC;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      hold_q       <= '0;
      drain_addr_q <= '0;
    end else begin
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      hold_q       <= hold_d;
      drain_addr_q <= drain_addr_d;
    end
  end

  assign pc         = pc_q;
  assign IF_IDpc    = ifid_pc_q;
  assign IF_IDinstr = ifid_instr_q;
  assign IF_IDvalid = ifid_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: sequential fetch, stall/hold, flush
// under stall, redirect with drain, wait states and asynchronous reset.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        PCwrite;
  logic        IF_IDwrite;
  logic        flush;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] IF_IDpc;
  logic [31:0] IF_IDinstr;
  logic        IF_IDvalid;

  int total = 0;
  int bad   = 0;

  fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .PCwrite      (PCwrite),
    .IF_IDwrite   (IF_IDwrite),
    .flush        (flush),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .pc           (pc),
    .IF_IDpc      (IF_IDpc),
    .IF_IDinstr   (IF_IDinstr),
    .IF_IDvalid   (IF_IDvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: address 8 holds addi x1,x0,10; elsewhere a tag of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h8) return 32'h00A0_0093;
    return {16'hC0DE, addr[15:0]};
  endfunction

  always_comb imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    flush         = 1'b0;
    PCwrite       = 1'b1;
    IF_IDwrite    = 1'b1;
    imem_ready    = 1'b0;
    branch_target = 32'h0;
    reset         = 1'b1;
    #2;
    reset         = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    total++;
    if ({pc, IF_IDpc, IF_IDinstr, IF_IDvalid} !== {32'h0, 32'h0, 32'h13, 1'b0}) begin
      bad++;
      $display("FAIL reset_async: got pc=%h ifid=%h/%h/%b want 0/0/13/0", pc, IF_IDpc, IF_IDinstr, IF_IDvalid);
    end
    tick();
    reset = 1'b0;
    #1;
    total++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      bad++;
      $display("FAIL reset_first_req: got req=%b addr=%h want 1/0", imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_instr [4] = '{32'hC0DE_0000, 32'hC0DE_0004, 32'h00A0_0093, 32'hC0DE_000C};
    apply_reset();
    imem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if ({IF_IDpc, IF_IDinstr, IF_IDvalid} !== {32'(4 * i), exp_instr[i], 1'b1}) begin
        bad++;
        $display("FAIL seq_ifid[%0d]: got %h/%h/%b want %h/%h/1", i, IF_IDpc, IF_IDinstr, IF_IDvalid, 32'(4 * i), exp_instr[i]);
      end
    end
    total++;
    if (pc !== 32'h10) begin
      bad++;
      $display("FAIL seq_pc: got %h want 00000010", pc);
    end
  endtask

  task automatic test_stall_hold();
    apply_reset();
    imem_ready = 1'b1;
    tick();
    tick();
    PCwrite    = 1'b0;
    IF_IDwrite = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      imem_ready = 1'b0;
      total++;
      if ({imem_req, pc, IF_IDpc, IF_IDinstr, IF_IDvalid} !== {1'b0, 32'h8, 32'h4, 32'hC0DE_0004, 1'b1}) begin
        bad++;
        $display("FAIL stall_hold[%0d]: got req=%b pc=%h ifid=%h/%h/%b want 0/8/4/c0de0004/1", i, imem_req, pc, IF_IDpc, IF_IDinstr, IF_IDvalid);
      end
    end
    PCwrite    = 1'b1;
    IF_IDwrite = 1'b1;
    tick();
    total++;
    if ({pc, IF_IDpc, IF_IDinstr, IF_IDvalid} !== {32'hC, 32'h8, 32'h00A0_0093, 1'b1}) begin
      bad++;
      $display("FAIL stall_release: got pc=%h ifid=%h/%h/%b want c/8/00a00093/1", pc, IF_IDpc, IF_IDinstr, IF_IDvalid);
    end
    total++;
    if ({imem_req, imem_addr} !== {1'b1, 32'hC}) begin
      bad++;
      $display("FAIL stall_next_req: got req=%b addr=%h want 1/c", imem_req, imem_addr);
    end
  endtask

  task automatic test_flush_stall();
    apply_reset();
    imem_ready = 1'b1;
    tick();
    flush         = 1'b1;
    branch_target = 32'h100;
    PCwrite       = 1'b0;
    IF_IDwrite    = 1'b0;
    tick();
    total++;
    if ({pc, IF_IDpc, IF_IDinstr, IF_IDvalid} !== {32'h100, 32'h100, 32'h13, 1'b0}) begin
      bad++;
      $display("FAIL flush_stall: got pc=%h ifid=%h/%h/%b want 100/100/13/0", pc, IF_IDpc, IF_IDinstr, IF_IDvalid);
    end
    total++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h100}) begin
      bad++;
      $display("FAIL flush_stall_req: got req=%b addr=%h want 1/100", imem_req, imem_addr);
    end
    flush      = 1'b0;
    PCwrite    = 1'b1;
    IF_IDwrite = 1'b1;
    tick();
    total++;
    if ({pc, IF_IDpc, IF_IDinstr, IF_IDvalid} !== {32'h104, 32'h100, 32'hC0DE_0100, 1'b1}) begin
      bad++;
      $display("FAIL flush_target_fetch: got pc=%h ifid=%h/%h/%b want 104/100/c0de0100/1", pc, IF_IDpc, IF_IDinstr, IF_IDvalid);
    end
    // Enter HOLD, then flush: the buffered word must be discarded.
    PCwrite = 1'b0;
    tick();
    flush         = 1'b1;
    branch_target = 32'h200;
    tick();
    flush   = 1'b0;
    PCwrite = 1'b1;
    tick();
    total++;
    if ({pc, IF_IDpc, IF_IDinstr, IF_IDvalid} !== {32'h204, 32'h200, 32'hC0DE_0200, 1'b1}) begin
      bad++;
      $display("FAIL flush_from_hold: got pc=%h ifid=%h/%h/%b want 204/200/c0de0200/1", pc, IF_IDpc, IF_IDinstr, IF_IDvalid);
    end
  endtask

  task automatic test_flush_drain();
    apply_reset();
    imem_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    imem_ready = 1'b0;
    tick();
    total++;
    if ({imem_addr, pc, IF_IDpc, IF_IDinstr, IF_IDvalid} !== {32'h20, 32'h20, 32'h20, 32'h13, 1'b0}) begin
      bad++;
      $display("FAIL drain_pending: got addr=%h pc=%h ifid=%h/%h/%b want 20/20/20/13/0", imem_addr, pc, IF_IDpc, IF_IDinstr, IF_IDvalid);
    end
    flush         = 1'b1;
    branch_target = 32'h40;
    tick();
    total++;
    if ({imem_req, imem_addr, pc, IF_IDpc, IF_IDvalid} !== {1'b1, 32'h20, 32'h40, 32'h40, 1'b0}) begin
      bad++;
      $display("FAIL drain_enter: got req=%b addr=%h pc=%h ifidpc=%h v=%b want 1/20/40/40/0", imem_req, imem_addr, pc, IF_IDpc, IF_IDvalid);
    end
    branch_target = 32'h80;
    tick();
    total++;
    if ({imem_addr, pc} !== {32'h20, 32'h80}) begin
      bad++;
      $display("FAIL drain_reflush: got addr=%h pc=%h want 20/80", imem_addr, pc);
    end
    flush = 1'b0;
    tick();
    total++;
    if ({imem_req, imem_addr, IF_IDpc, IF_IDinstr, IF_IDvalid} !== {1'b1, 32'h20, 32'h80, 32'h13, 1'b0}) begin
      bad++;
      $display("FAIL drain_wait: got req=%b addr=%h ifid=%h/%h/%b want 1/20/80/13/0", imem_req, imem_addr, IF_IDpc, IF_IDinstr, IF_IDvalid);
    end
    imem_ready = 1'b1;
    tick();
    total++;
    if ({imem_addr, pc, IF_IDinstr, IF_IDvalid} !== {32'h80, 32'h80, 32'h13, 1'b0}) begin
      bad++;
      $display("FAIL drain_discard: got addr=%h pc=%h instr=%h v=%b want 80/80/13/0", imem_addr, pc, IF_IDinstr, IF_IDvalid);
    end
    tick();
    total++;
    if ({pc, IF_IDpc, IF_IDinstr, IF_IDvalid} !== {32'h84, 32'h80, 32'hC0DE_0080, 1'b1}) begin
      bad++;
      $display("FAIL drain_resume: got pc=%h ifid=%h/%h/%b want 84/80/c0de0080/1", pc, IF_IDpc, IF_IDinstr, IF_IDvalid);
    end
  endtask

  task automatic test_wait_states();
    apply_reset();
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if ({pc, IF_IDpc, IF_IDinstr, IF_IDvalid} !== {32'h4, 32'h4, 32'h13, 1'b0}) begin
        bad++;
        $display("FAIL wait_bubble[%0d]: got pc=%h ifid=%h/%h/%b want 4/4/13/0", i, pc, IF_IDpc, IF_IDinstr, IF_IDvalid);
      end
    end
    imem_ready = 1'b1;
    tick();
    total++;
    if ({pc, IF_IDpc, IF_IDinstr, IF_IDvalid} !== {32'h8, 32'h4, 32'hC0DE_0004, 1'b1}) begin
      bad++;
      $display("FAIL wait_complete: got pc=%h ifid=%h/%h/%b want 8/4/c0de0004/1", pc, IF_IDpc, IF_IDinstr, IF_IDvalid);
    end
  endtask

  task automatic test_async_reset_hold();
    apply_reset();
    imem_ready = 1'b1;
    tick();
    PCwrite = 1'b0;
    tick();
    total++;
    if (imem_req !== 1'b0) begin
      bad++;
      $display("FAIL areset_in_hold: got req=%b want 0", imem_req);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({imem_req, imem_addr, pc, IF_IDpc, IF_IDinstr, IF_IDvalid} !== {1'b1, 32'h0, 32'h0, 32'h0, 32'h13, 1'b0}) begin
      bad++;
      $display("FAIL areset_between_edges: got req=%b addr=%h pc=%h ifid=%h/%h/%b want 1/0/0/0/13/0", imem_req, imem_addr, pc, IF_IDpc, IF_IDinstr, IF_IDvalid);
    end
    reset   = 1'b0;
    PCwrite = 1'b1;
    tick();
    total++;
    if ({pc, IF_IDpc, IF_IDinstr, IF_IDvalid} !== {32'h4, 32'h0, 32'hC0DE_0000, 1'b1}) begin
      bad++;
      $display("FAIL areset_restart: got pc=%h ifid=%h/%h/%b want 4/0/c0de0000/1", pc, IF_IDpc, IF_IDinstr, IF_IDvalid);
    end
  endtask

  initial begin
    reset         = 1'b0;
    PCwrite       = 1'b1;
    IF_IDwrite    = 1'b1;
    flush         = 1'b0;
    branch_target = 32'h0;
    imem_ready    = 1'b0;
    test_reset();
    test_sequential();
    test_stall_hold();
    test_flush_stall();
    test_flush_drain();
    test_wait_states();
    test_async_reset_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
